// File: rtl/ov7670_capture_multi.sv
// OV7670 byte-stream capture into a linear frame buffer with selectable 1:1/1:2/1:4
// decimation, RGB444/RGB565 packing, frame accounting and malformed-line/overflow flags.
module ov7670_capture_multi #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic [1:0]        scale,
    input  logic              fmt,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              line_err,
    output logic              overflow
);

    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] ACTIVE     = 1'b1;

    localparam int LINE_BYTES = 2 * H_ACTIVE;
    localparam int BC_W       = $clog2(LINE_BYTES + 2);
    localparam int XW         = $clog2(H_ACTIVE + 1);
    localparam int YW         = $clog2(V_ACTIVE + 2);

    localparam logic [BC_W-1:0]   BC_LINE = BC_W'(LINE_BYTES);
    localparam logic [BC_W-1:0]   BC_MAX  = BC_W'(LINE_BYTES + 1);
    localparam logic [ADDR_W-1:0] LAST1   = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LAST2   = ADDR_W'((H_ACTIVE / 2) * (V_ACTIVE / 2) - 1);
    localparam logic [ADDR_W-1:0] LAST4   = ADDR_W'((H_ACTIVE / 4) * (V_ACTIVE / 4) - 1);

    // Reset asserts asynchronously but is released on a pclk edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic              vsync_q;
    logic              href_q;
    logic [0:0]        state_q;
    logic              phase_q;
    logic [7:0]        b0_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [BC_W-1:0]   byte_cnt_q;
    logic [1:0]        scale_q;
    logic              fmt_q;
    logic              full_q;
    logic              wrote_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              we_q;
    logic              frame_done_q;
    logic [7:0]        frame_count_q;
    logic              line_err_q;
    logic              overflow_q;

    logic              vs_rise;
    logic              vs_fall;
    logic              href_fall;
    logic              byte_ok;
    logic              pix_done;
    logic              keep;
    logic              store;
    logic [1:0]        mask;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] pix_data;

    assign vs_rise   = vsync & ~vsync_q;
    assign vs_fall   = ~vsync & vsync_q;
    assign href_fall = href_q & ~href;
    // Bytes presented while vsync is high are blanking noise and never form pixels.
    assign byte_ok   = href & ~vsync;
    assign pix_done  = byte_ok & phase_q;

    always_comb begin
        mask      = 2'b11;
        last_addr = LAST4;
        unique case (scale_q)
            2'b00: begin
                mask      = 2'b00;
                last_addr = LAST1;
            end
            2'b01: begin
                mask      = 2'b01;
                last_addr = LAST2;
            end
            default: begin
                mask      = 2'b11;
                last_addr = LAST4;
            end
        endcase
    end

    assign keep  = ((x_q[1:0] & mask) == 2'b00) && ((y_q[1:0] & mask) == 2'b00);
    assign store = pix_done & keep & (state_q == ACTIVE);

    always_comb begin
        pix_data = '0;
        if (!fmt_q) begin
            pix_data = DATA_W'({b0_q[3:0], d});
        end else if (DATA_W == 16) begin
            pix_data = DATA_W'({b0_q, d});
        end else begin
            // RGB565 squeezed to 4:4:4 by keeping the top bits of each channel.
            pix_data = DATA_W'({b0_q[7:4], b0_q[2:0], d[7], d[4:1]});
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            state_q       <= WAIT_FRAME;
            phase_q       <= 1'b0;
            b0_q          <= 8'h00;
            x_q           <= '0;
            y_q           <= '0;
            byte_cnt_q    <= '0;
            scale_q       <= 2'b00;
            fmt_q         <= 1'b0;
            full_q        <= 1'b0;
            wrote_q       <= 1'b0;
            addr_q        <= '0;
            dout_q        <= '0;
            we_q          <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'h00;
            line_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            href_q       <= href;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;

            if (state_q == WAIT_FRAME && vs_fall) begin
                state_q <= ACTIVE;
            end

            phase_q <= byte_ok ? ~phase_q : 1'b0;
            if (byte_ok && !phase_q) begin
                b0_q <= d;
            end

            if (byte_ok) begin
                if (byte_cnt_q != BC_MAX) begin
                    byte_cnt_q <= byte_cnt_q + BC_W'(1);
                end
            end else begin
                byte_cnt_q <= '0;
            end

            if (href_fall && !vsync && state_q == ACTIVE && byte_cnt_q != BC_LINE) begin
                line_err_q <= 1'b1;
            end

            if (store) begin
                if (full_q) begin
                    overflow_q <= 1'b1;
                end else begin
                    we_q   <= 1'b1;
                    dout_q <= pix_data;
                end
            end

            // Once the last slot is written the address parks there for the rest of the frame.
            if (we_q) begin
                wrote_q <= 1'b1;
                if (addr_q == last_addr) begin
                    full_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end

            if (!href) begin
                x_q <= '0;
            end else if (pix_done) begin
                x_q <= x_q + XW'(1);
            end

            if (href_fall) begin
                y_q <= y_q + YW'(1);
            end

            if (vsync) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
                full_q <= 1'b0;
            end

            if (vs_rise) begin
                scale_q    <= scale;
                fmt_q      <= fmt;
                line_err_q <= 1'b0;
                overflow_q <= 1'b0;
                wrote_q    <= 1'b0;
                if (wrote_q || we_q) begin
                    frame_done_q  <= 1'b1;
                    frame_count_q <= frame_count_q + 8'd1;
                end
            end
        end
    end

    assign addr        = addr_q;
    assign dout        = dout_q;
    assign we          = we_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign line_err    = line_err_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/ov7670_capture_multi.md
OV7670_CAPTURE_MULTI -- requirements
Module: ov7670_capture_multi

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per camera line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per camera frame.
REQ-003 Parameter DATA_W, default 12, write-data width; legal values 12 or 16.
REQ-004 Parameter ADDR_W, default 19, write-address width.
REQ-005 pclk  in  1  camera pixel clock; sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 vsync  in  1  camera frame sync; high = vertical blanking.
REQ-008 href  in  1  camera line valid.
REQ-009 d  in  8  camera data byte.
REQ-010 scale  in  2  decimation: 00 = 1:1, 01 = 1:2, 10/11 = 1:4 in both axes.
REQ-011 fmt  in  1  camera byte format: 0 = RGB444, 1 = RGB565.
REQ-012 addr  out  ADDR_W  frame-buffer write address.
REQ-013 dout  out  DATA_W  frame-buffer write data.
REQ-014 we  out  1  write strobe, one pclk per stored pixel.
REQ-015 frame_done  out  1  one-cycle pulse at end of frame.
REQ-016 frame_count  out  8  count of completed frames.
REQ-017 line_err  out  1  sticky flag for a malformed line.
REQ-018 overflow  out  1  sticky flag for a write past frame capacity.

Function
REQ-019 Sample vsync, href, and d on every pclk rising edge, with no extra input synchronisers.
REQ-020 Toggle the byte phase on each sampled byte while href=1: phase 0 captures the high byte and phase 1 completes the pixel.
REQ-021 Force the byte phase to 0 while href=0, so a trailing odd byte is discarded and no write occurs.
REQ-022 Increment column counter x on each completed pixel; clear x when href=0; increment row counter y on each href falling edge; clear x, y, and addr while vsync=1.
REQ-023 Latch scale and fmt into active-mode registers on the vsync rising edge only, so changes mid-frame take effect from the next frame.
REQ-024 Store a completed pixel only when x and y are both divisible by the active decimation factor, i.e. low 0, 1, or 2 bits of x and y are zero.
REQ-025 For RGB444 (fmt=0), form dout = {b0[3:0], b1[7:0]} zero-extended to DATA_W.
REQ-026 For RGB565 (fmt=1) with DATA_W=16, form dout = {b0, b1}.
REQ-027 For RGB565 (fmt=1) with DATA_W=12, form dout = {b0[7:4], b0[2:0], b1[7], b1[4:1]}, i.e. R[4:1], G[5:2], B[4:1].
REQ-028 Assert we for exactly one cycle, in the cycle after the edge that sampled the second byte; dout and addr are valid in that same cycle.
REQ-029 Increment addr by 1 in the cycle after each we; the first pixel of a frame is written at addr 0.
REQ-030 Capacity is CAP = (H_ACTIVE/f)*(V_ACTIVE/f) for decimation factor f.
REQ-031 When addr reaches CAP, suppress further we, hold addr at CAP-1, and set overflow.
REQ-032 On each href falling edge, set line_err if the line byte count is not 2*H_ACTIVE.
REQ-033 Clear line_err and overflow on the vsync rising edge, which opens a new frame.
REQ-034 Pulse frame_done for one cycle on the vsync rising edge only if at least one we occurred since the previous vsync.
REQ-035 In the same cycle as frame_done, increment frame_count, wrapping 255 to 0.
REQ-036 State machine: WAIT_FRAME (after reset, until the first vsync falling edge) -> ACTIVE (capture enabled) -> ACTIVE on the next vsync rising edge (frame_done, re-arm).
REQ-037 In WAIT_FRAME, produce no we, so a partial frame after reset is never stored.
REQ-038 If href=1 while vsync=1, ignore the data and produce no we.

Reset
REQ-039 While reset=0, asynchronously force addr=0, dout=0, we=0, frame_done=0, frame_count=0, line_err=0, overflow=0, x=0, y=0, byte phase=0, active scale=00, active fmt=0, state=WAIT_FRAME.
REQ-040 Release reset synchronously to pclk; a reset asserted mid-line aborts the pending pixel with no we.

Verification
REQ-041 Full frame, defaults, scale=00, fmt=0, bytes 0x0A,0xBC per pixel -> 307200 we pulses, dout=0xABC, last addr=307199, frame_done=1 once, frame_count=1.
REQ-042 scale=10 set during vsync, 640x480 frame -> 19200 we pulses, at x,y multiples of 4 only, last addr=19199, overflow=0.
REQ-043 fmt=1, DATA_W=12, bytes 0xF8,0x1F -> dout=0xF0F; same bytes with DATA_W=16 -> dout=0xF81F.
REQ-044 One line of 1279 bytes -> 639 we on that line, line_err=1 until the next vsync rising edge, then 0.
REQ-045 scale changed 00 -> 01 mid-frame -> that frame still produces 307200 we pulses; the next frame produces 76800.
REQ-046 reset pulsed low mid-line -> all outputs 0 immediately, no we until the first vsync falling edge, then capture from addr 0.
